// File: rtl/br_pred_stats_if.sv
// Bundle of event, control and readback signals for the branch-prediction
// statistics unit. The monitored core (or a bench) takes the master side,
// the statistics unit takes the slave side.
interface br_pred_stats_if #(
    parameter int CNT_W      = 32,
    parameter int NUM_CH     = 4,
    parameter int EPOCH_LOG2 = 8
);
    localparam int CH_W = $clog2(NUM_CH);

    logic                  i_is_br;
    logic [CH_W-1:0]       i_ch;
    logic                  i_is_correct;
    logic                  i_freeze;
    logic                  i_clear;
    logic [CH_W-1:0]       i_rd_ch;
    logic                  i_rd_sel;
    logic [CNT_W-1:0]      o_rd_data;
    logic                  o_busy;
    logic                  o_epoch_done;
    logic [EPOCH_LOG2:0]   o_epoch_miss;
    logic                  o_alarm;
    logic                  o_any_sat;

    modport master (
        output i_is_br, i_ch, i_is_correct, i_freeze, i_clear, i_rd_ch, i_rd_sel,
        input  o_rd_data, o_busy, o_epoch_done, o_epoch_miss, o_alarm, o_any_sat
    );

    modport slave (
        input  i_is_br, i_ch, i_is_correct, i_freeze, i_clear, i_rd_ch, i_rd_sel,
        output o_rd_data, o_busy, o_epoch_done, o_epoch_miss, o_alarm, o_any_sat
    );
endinterface

// File: rtl/br_pred_stats.sv
// Branch-prediction statistics unit: per-class saturating event/miss counters,
// fixed-length epoch miss measurement with a sticky alarm, indexed readback
// and a one-channel-per-cycle clear sweep.
module br_pred_stats #(
    parameter int CNT_W      = 32,
    parameter int NUM_CH     = 4,
    parameter int CH_W       = $clog2(NUM_CH),
    parameter int EPOCH_LOG2 = 8,
    parameter int ALARM_THR  = 32
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    br_pred_stats_if.slave bus
);

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int               EP_W    = EPOCH_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

    state_e            state_q;
    logic [CH_W-1:0]   sweepIdx_q;
    logic              busy_q;

    logic [CNT_W-1:0]  total_q [NUM_CH];
    logic [CNT_W-1:0]  total_d [NUM_CH];
    logic [CNT_W-1:0]  miss_q  [NUM_CH];
    logic [CNT_W-1:0]  miss_d  [NUM_CH];

    logic [EPOCH_LOG2-1:0] epCnt_q, epCnt_d;
    logic [EP_W-1:0]       epMiss_q, epMiss_d;
    logic [EP_W-1:0]       epochMiss_q, epochMiss_d;
    logic                  epochDone_q, epochDone_d;
    logic                  alarm_q, alarm_d;
    logic                  anySat_q, anySat_d;
    logic [CNT_W-1:0]      rdData_d, rdData_q;

    logic              chValid;
    logic              accept;
    logic              isMiss;
    logic              sweepActive;
    logic              sweepFirst;
    logic              anySatHit;
    logic [EP_W-1:0]   epTotal;

    // Events are only taken while running, unfrozen and for an existing class
    assign chValid     = (32'(bus.i_ch) < 32'(NUM_CH));
    assign accept      = (state_q == RUN) && bus.i_is_br && !bus.i_freeze && chValid;
    assign isMiss      = accept && !bus.i_is_correct;
    assign sweepActive = (state_q == CLEAR);
    assign sweepFirst  = sweepActive && (sweepIdx_q == '0);
    assign epTotal     = epMiss_q + EP_W'(isMiss);

    // Per-channel counter next state: sweep zeroing wins, otherwise saturating increment
    always_comb begin
        anySatHit = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            total_d[c] = total_q[c];
            miss_d[c]  = miss_q[c];
            if (sweepActive && (sweepIdx_q == CH_W'(c))) begin
                total_d[c] = '0;
                miss_d[c]  = '0;
            end else if (accept && (bus.i_ch == CH_W'(c))) begin
                if (total_q[c] != CNT_MAX) begin
                    total_d[c] = total_q[c] + CNT_W'(1);
                end
                if (isMiss && (miss_q[c] != CNT_MAX)) begin
                    miss_d[c] = miss_q[c] + CNT_W'(1);
                end
                if ((total_d[c] == CNT_MAX) || (miss_d[c] == CNT_MAX)) begin
                    anySatHit = 1'b1;
                end
            end
        end
    end

    // Sticky saturation flag, dropped only at the start of a clear sweep
    always_comb begin
        anySat_d = anySat_q | anySatHit;
        if (sweepFirst) begin
            anySat_d = 1'b0;
        end
    end

    // Epoch bookkeeping: latch the miss count when the epoch fills, raise the sticky alarm
    always_comb begin
        epCnt_d     = epCnt_q;
        epMiss_d    = epMiss_q;
        epochMiss_d = epochMiss_q;
        epochDone_d = 1'b0;
        alarm_d     = alarm_q;
        if (sweepFirst) begin
            epCnt_d     = '0;
            epMiss_d    = '0;
            epochMiss_d = '0;
            alarm_d     = 1'b0;
        end else if (accept) begin
            if (epCnt_q == '1) begin
                epCnt_d     = '0;
                epMiss_d    = '0;
                epochMiss_d = epTotal;
                epochDone_d = 1'b1;
                if (32'(epTotal) > 32'(ALARM_THR)) begin
                    alarm_d = 1'b1;
                end
            end else begin
                epCnt_d  = epCnt_q + EPOCH_LOG2'(1);
                epMiss_d = epTotal;
            end
        end
    end

    // Readback mux samples the pre-update counters so same-cycle updates are not seen
    always_comb begin
        rdData_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (bus.i_rd_ch == CH_W'(c)) begin
                rdData_d = bus.i_rd_sel ? miss_q[c] : total_q[c];
            end
        end
    end

    // Run/clear controller: a clear request starts a sweep of exactly NUM_CH cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= RUN;
            sweepIdx_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.i_clear) begin
                        state_q    <= CLEAR;
                        sweepIdx_q <= '0;
                        busy_q     <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (sweepIdx_q == LAST_CH) begin
                        state_q    <= RUN;
                        sweepIdx_q <= '0;
                        busy_q     <= 1'b0;
                    end else begin
                        sweepIdx_q <= sweepIdx_q + CH_W'(1);
                    end
                end
                default: begin
                    state_q    <= RUN;
                    sweepIdx_q <= '0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    // Counter, epoch and readback registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                total_q[c] <= '0;
                miss_q[c]  <= '0;
            end
            epCnt_q     <= '0;
            epMiss_q    <= '0;
            epochMiss_q <= '0;
            epochDone_q <= 1'b0;
            alarm_q     <= 1'b0;
            anySat_q    <= 1'b0;
            rdData_q    <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                total_q[c] <= total_d[c];
                miss_q[c]  <= miss_d[c];
            end
            epCnt_q     <= epCnt_d;
            epMiss_q    <= epMiss_d;
            epochMiss_q <= epochMiss_d;
            epochDone_q <= epochDone_d;
            alarm_q     <= alarm_d;
            anySat_q    <= anySat_d;
            rdData_q    <= rdData_d;
        end
    end

    assign bus.o_rd_data    = rdData_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_epoch_done = epochDone_q;
    assign bus.o_epoch_miss = epochMiss_q;
    assign bus.o_alarm      = alarm_q;
    assign bus.o_any_sat    = anySat_q;

endmodule

// File: tb/tb_br_pred_stats.sv
// Bench for br_pred_stats: randomized event streams checked against a
// counting model of the statistics unit (small counters, short epochs,
// non-power-of-two class count).
module tb_br_pred_stats;

    localparam int CNT_W      = 8;
    localparam int NUM_CH     = 3;
    localparam int CH_W       = $clog2(NUM_CH);
    localparam int EPOCH_LOG2 = 4;
    localparam int ALARM_THR  = 3;
    localparam int EPOCH_LEN  = 1 << EPOCH_LOG2;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    logic i_clk;
    logic i_rst_n;

    int checks = 0;
    int errors = 0;

    int mTotal [NUM_CH];
    int mMiss  [NUM_CH];
    int mEpCnt;
    int mEpMiss;
    int mEpochMiss;
    bit mAlarm;
    bit mSat;

    br_pred_stats_if #(.CNT_W(CNT_W), .NUM_CH(NUM_CH), .EPOCH_LOG2(EPOCH_LOG2)) bus ();

    br_pred_stats #(
        .CNT_W(CNT_W), .NUM_CH(NUM_CH), .CH_W(CH_W),
        .EPOCH_LOG2(EPOCH_LOG2), .ALARM_THR(ALARM_THR)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .bus    (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Everything forgotten: reset or a completed clear sweep
    function automatic void modelReset();
        for (int c = 0; c < NUM_CH; c++) begin
            mTotal[c] = 0;
            mMiss[c]  = 0;
        end
        mEpCnt     = 0;
        mEpMiss    = 0;
        mEpochMiss = 0;
        mAlarm     = 1'b0;
        mSat       = 1'b0;
    endfunction

    // One resolved branch in RUN; returns whether it closes an epoch
    function automatic bit modelEvent(int ch, bit correct, bit freeze);
        if (freeze || ch >= NUM_CH) return 1'b0;
        if (mTotal[ch] < CNT_MAX) mTotal[ch]++;
        if (mTotal[ch] == CNT_MAX) mSat = 1'b1;
        if (!correct) begin
            if (mMiss[ch] < CNT_MAX) mMiss[ch]++;
            if (mMiss[ch] == CNT_MAX) mSat = 1'b1;
            mEpMiss++;
        end
        mEpCnt++;
        if (mEpCnt == EPOCH_LEN) begin
            mEpochMiss = mEpMiss;
            if (mEpMiss > ALARM_THR) mAlarm = 1'b1;
            mEpCnt  = 0;
            mEpMiss = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic applyStimulus(input bit isBr, input int ch, input bit correct, input bit freeze,
                                 input bit clr, input int rdCh, input bit rdSel,
                                 output bit done, output int rd);
        bus.i_is_br      = isBr;
        bus.i_ch         = CH_W'(ch);
        bus.i_is_correct = correct;
        bus.i_freeze     = freeze;
        bus.i_clear      = clr;
        bus.i_rd_ch      = CH_W'(rdCh);
        bus.i_rd_sel     = rdSel;
        @(posedge i_clk);
        #1;
        done = bus.o_epoch_done;
        rd   = int'(bus.o_rd_data);
        bus.i_is_br  = 1'b0;
        bus.i_freeze = 1'b0;
        bus.i_clear  = 1'b0;
    endtask

    task automatic test_reset();
        bit done;
        int rd;
        int exp;
        i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", bus.o_busy); end
        checks++; if (bus.o_epoch_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %0b expected 0", bus.o_epoch_done); end
        checks++; if (bus.o_epoch_miss !== '0) begin errors++; $display("[TB] FAIL reset_epoch_miss: got %0d expected 0", bus.o_epoch_miss); end
        checks++; if (bus.o_alarm !== 1'b0) begin errors++; $display("[TB] FAIL reset_alarm: got %0b expected 0", bus.o_alarm); end
        checks++; if (bus.o_any_sat !== 1'b0) begin errors++; $display("[TB] FAIL reset_sat: got %0b expected 0", bus.o_any_sat); end
        checks++; if (bus.o_rd_data !== '0) begin errors++; $display("[TB] FAIL reset_rd_data: got %0d expected 0", bus.o_rd_data); end
        i_rst_n = 1'b1;
        modelReset();
        for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < 2; s++) begin
                applyStimulus(0, 0, 1, 0, 0, c, (s != 0), done, rd);
                exp = (s != 0) ? mMiss[c] : mTotal[c];
                checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL reset_read ch%0d sel%0d: got %0d expected %0d", c, s, rd, exp); end
            end
        end
    endtask

    task automatic test_basic_count();
        bit done, expDone, correct;
        int rd, exp, missLeft;
        missLeft = 3;
        for (int i = 0; i < 10; i++) begin
            correct = !($urandom_range(0, 9 - i) < missLeft);
            if (!correct) missLeft--;
            expDone = modelEvent(2, correct, 0);
            applyStimulus(1, 2, correct, 0, 0, 0, 0, done, rd);
            checks++; if (done !== expDone) begin errors++; $display("[TB] FAIL basic_done ev%0d: got %0b expected %0b", i, done, expDone); end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < 2; s++) begin
                applyStimulus(0, 0, 1, 0, 0, c, (s != 0), done, rd);
                exp = (s != 0) ? mMiss[c] : mTotal[c];
                checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL basic_read ch%0d sel%0d: got %0d expected %0d", c, s, rd, exp); end
            end
        end
    endtask

    task automatic test_freeze_oob();
        bit done, expDone, correct;
        int rd, exp, ch;
        for (int i = 0; i < 5; i++) begin
            ch = $urandom_range(0, NUM_CH - 1);
            correct = ($urandom_range(0, 1) == 1);
            expDone = modelEvent(ch, correct, 1);
            applyStimulus(1, ch, correct, 1, 0, 0, 0, done, rd);
            checks++; if (done !== expDone) begin errors++; $display("[TB] FAIL freeze_done ev%0d: got %0b expected %0b", i, done, expDone); end
        end
        for (int i = 0; i < 4; i++) begin
            expDone = modelEvent(NUM_CH, 0, 0);
            applyStimulus(1, NUM_CH, 0, 0, 0, 0, 0, done, rd);
            checks++; if (done !== expDone) begin errors++; $display("[TB] FAIL oob_done ev%0d: got %0b expected %0b", i, done, expDone); end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < 2; s++) begin
                applyStimulus(0, 0, 1, 0, 0, c, (s != 0), done, rd);
                exp = (s != 0) ? mMiss[c] : mTotal[c];
                checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL freeze_read ch%0d sel%0d: got %0d expected %0d", c, s, rd, exp); end
            end
        end
        // Only real events advance the epoch, so it closes exactly when the model says
        for (int i = 0; i < EPOCH_LEN; i++) begin
            ch = $urandom_range(0, NUM_CH - 1);
            correct = ($urandom_range(0, 1) == 1);
            expDone = modelEvent(ch, correct, 0);
            applyStimulus(1, ch, correct, 0, 0, 0, 0, done, rd);
            checks++; if (done !== expDone) begin errors++; $display("[TB] FAIL freeze_epoch_done ev%0d: got %0b expected %0b", i, done, expDone); end
            if (expDone) break;
        end
        checks++; if (int'(bus.o_epoch_miss) !== mEpochMiss) begin errors++; $display("[TB] FAIL freeze_epoch_miss: got %0d expected %0d", bus.o_epoch_miss, mEpochMiss); end
    endtask

    task automatic test_epoch_alarm();
        bit done, expDone;
        bit missAt [EPOCH_LEN];
        int rd, ch, placed, p;
        for (int i = 0; i < EPOCH_LEN && mEpCnt != 0; i++) begin
            ch = $urandom_range(0, NUM_CH - 1);
            expDone = modelEvent(ch, 1, 0);
            applyStimulus(1, ch, 1, 0, 0, 0, 0, done, rd);
            checks++; if (done !== expDone) begin errors++; $display("[TB] FAIL align_done ev%0d: got %0b expected %0b", i, done, expDone); end
        end
        for (int i = 0; i < EPOCH_LEN; i++) missAt[i] = 1'b0;
        missAt[EPOCH_LEN - 1] = 1'b1;
        placed = 0;
        while (placed < 3) begin
            p = $urandom_range(0, EPOCH_LEN - 2);
            if (!missAt[p]) begin
                missAt[p] = 1'b1;
                placed++;
            end
        end
        for (int i = 0; i < EPOCH_LEN; i++) begin
            ch = $urandom_range(0, NUM_CH - 1);
            expDone = modelEvent(ch, !missAt[i], 0);
            applyStimulus(1, ch, !missAt[i], 0, 0, 0, 0, done, rd);
            checks++; if (done !== expDone) begin errors++; $display("[TB] FAIL epoch_done ev%0d: got %0b expected %0b", i, done, expDone); end
        end
        checks++; if (int'(bus.o_epoch_miss) !== mEpochMiss) begin errors++; $display("[TB] FAIL epoch_miss_4: got %0d expected %0d", bus.o_epoch_miss, mEpochMiss); end
        checks++; if (bus.o_alarm !== mAlarm) begin errors++; $display("[TB] FAIL epoch_alarm_set: got %0b expected %0b", bus.o_alarm, mAlarm); end
        applyStimulus(0, 0, 1, 0, 0, 0, 0, done, rd);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL epoch_done_single: got %0b expected 0", done); end
        for (int i = 0; i < EPOCH_LEN; i++) begin
            ch = $urandom_range(0, NUM_CH - 1);
            expDone = modelEvent(ch, 1, 0);
            applyStimulus(1, ch, 1, 0, 0, 0, 0, done, rd);
            checks++; if (done !== expDone) begin errors++; $display("[TB] FAIL epoch2_done ev%0d: got %0b expected %0b", i, done, expDone); end
        end
        checks++; if (int'(bus.o_epoch_miss) !== mEpochMiss) begin errors++; $display("[TB] FAIL epoch_miss_0: got %0d expected %0d", bus.o_epoch_miss, mEpochMiss); end
        checks++; if (bus.o_alarm !== mAlarm) begin errors++; $display("[TB] FAIL epoch_alarm_sticky: got %0b expected %0b", bus.o_alarm, mAlarm); end
    endtask

    task automatic test_random_mix();
        bit done, expDone, isBr, correct, freeze, rdSel;
        int rd, ch, rdCh, expRd;
        for (int i = 0; i < 80; i++) begin
            isBr    = ($urandom_range(0, 3) != 0);
            ch      = $urandom_range(0, 3);
            correct = ($urandom_range(0, 2) != 0);
            freeze  = ($urandom_range(0, 4) == 0);
            rdCh    = $urandom_range(0, NUM_CH - 1);
            rdSel   = ($urandom_range(0, 1) == 1);
            expRd   = rdSel ? mMiss[rdCh] : mTotal[rdCh];
            expDone = isBr ? modelEvent(ch, correct, freeze) : 1'b0;
            applyStimulus(isBr, ch, correct, freeze, 0, rdCh, rdSel, done, rd);
            checks++; if (rd !== expRd) begin errors++; $display("[TB] FAIL random_read cyc%0d ch%0d sel%0b: got %0d expected %0d", i, rdCh, rdSel, rd, expRd); end
            checks++; if (done !== expDone) begin errors++; $display("[TB] FAIL random_done cyc%0d: got %0b expected %0b", i, done, expDone); end
        end
        checks++; if (bus.o_alarm !== mAlarm) begin errors++; $display("[TB] FAIL random_alarm: got %0b expected %0b", bus.o_alarm, mAlarm); end
        checks++; if (int'(bus.o_epoch_miss) !== mEpochMiss) begin errors++; $display("[TB] FAIL random_epoch_miss: got %0d expected %0d", bus.o_epoch_miss, mEpochMiss); end
    endtask

    task automatic test_clear_sweep();
        bit done, expDone;
        int rd, exp, expRd, busyCycles;
        expDone = modelEvent(2, 1, 0);
        applyStimulus(1, 2, 1, 0, 1, 2, 0, done, rd);
        checks++; if (done !== expDone) begin errors++; $display("[TB] FAIL clear_event_done: got %0b expected %0b", done, expDone); end
        expRd = mTotal[2];
        busyCycles = (bus.o_busy === 1'b1) ? 1 : 0;
        for (int cyc = 0; cyc < 10 && bus.o_busy === 1'b1; cyc++) begin
            applyStimulus(1, $urandom_range(0, NUM_CH - 1), 0, 0, (cyc == 1), 2, 0, done, rd);
            if (cyc == 0) begin
                checks++; if (rd !== expRd) begin errors++; $display("[TB] FAIL clear_read_in_sweep: got %0d expected %0d", rd, expRd); end
            end
            if (bus.o_busy === 1'b1) busyCycles++;
        end
        modelReset();
        checks++; if (busyCycles !== NUM_CH) begin errors++; $display("[TB] FAIL clear_busy_len: got %0d expected %0d", busyCycles, NUM_CH); end
        checks++; if (bus.o_alarm !== mAlarm) begin errors++; $display("[TB] FAIL clear_alarm: got %0b expected %0b", bus.o_alarm, mAlarm); end
        checks++; if (bus.o_any_sat !== mSat) begin errors++; $display("[TB] FAIL clear_sat: got %0b expected %0b", bus.o_any_sat, mSat); end
        checks++; if (int'(bus.o_epoch_miss) !== mEpochMiss) begin errors++; $display("[TB] FAIL clear_epoch_miss: got %0d expected %0d", bus.o_epoch_miss, mEpochMiss); end
        for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < 2; s++) begin
                applyStimulus(0, 0, 1, 0, 0, c, (s != 0), done, rd);
                exp = (s != 0) ? mMiss[c] : mTotal[c];
                checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL clear_read ch%0d sel%0d: got %0d expected %0d", c, s, rd, exp); end
            end
        end
        expDone = modelEvent(1, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, done, rd);
        applyStimulus(0, 0, 1, 0, 0, 1, 1, done, rd);
        checks++; if (rd !== mMiss[1]) begin errors++; $display("[TB] FAIL clear_resume: got %0d expected %0d", rd, mMiss[1]); end
    endtask

    task automatic test_saturation();
        bit done, expDone;
        int rd, exp;
        checks++; if (bus.o_any_sat !== mSat) begin errors++; $display("[TB] FAIL sat_before: got %0b expected %0b", bus.o_any_sat, mSat); end
        for (int i = 0; i < 260; i++) begin
            expDone = modelEvent(0, 1, 0);
            applyStimulus(1, 0, 1, 0, 0, 0, 0, done, rd);
            checks++; if (done !== expDone) begin errors++; $display("[TB] FAIL sat_done ev%0d: got %0b expected %0b", i, done, expDone); end
            checks++; if (bus.o_any_sat !== mSat) begin errors++; $display("[TB] FAIL sat_flag ev%0d: got %0b expected %0b", i, bus.o_any_sat, mSat); end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < 2; s++) begin
                applyStimulus(0, 0, 1, 0, 0, c, (s != 0), done, rd);
                exp = (s != 0) ? mMiss[c] : mTotal[c];
                checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL sat_read ch%0d sel%0d: got %0d expected %0d", c, s, rd, exp); end
            end
        end
    endtask

    task automatic test_reset_mid_sweep();
        bit done, expDone;
        int rd, exp, ch;
        for (int i = 0; i < 5; i++) begin
            ch = $urandom_range(1, NUM_CH - 1);
            expDone = modelEvent(ch, 0, 0);
            applyStimulus(1, ch, 0, 0, 0, 0, 0, done, rd);
        end
        applyStimulus(0, 0, 1, 0, 1, 2, 0, done, rd);
        applyStimulus(0, 0, 1, 0, 0, 2, 0, done, rd);
        i_rst_n = 1'b0;
        #2;
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %0b expected 0", bus.o_busy); end
        checks++; if (bus.o_rd_data !== '0) begin errors++; $display("[TB] FAIL midrst_rd_data: got %0d expected 0", bus.o_rd_data); end
        checks++; if (bus.o_alarm !== 1'b0 || bus.o_any_sat !== 1'b0 || bus.o_epoch_done !== 1'b0) begin
            errors++; $display("[TB] FAIL midrst_flags: got alarm=%0b sat=%0b done=%0b expected 0", bus.o_alarm, bus.o_any_sat, bus.o_epoch_done);
        end
        checks++; if (bus.o_epoch_miss !== '0) begin errors++; $display("[TB] FAIL midrst_epoch_miss: got %0d expected 0", bus.o_epoch_miss); end
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        modelReset();
        for (int c = 0; c < NUM_CH; c++) begin
            for (int s = 0; s < 2; s++) begin
                applyStimulus(0, 0, 1, 0, 0, c, (s != 0), done, rd);
                exp = (s != 0) ? mMiss[c] : mTotal[c];
                checks++; if (rd !== exp) begin errors++; $display("[TB] FAIL midrst_read ch%0d sel%0d: got %0d expected %0d", c, s, rd, exp); end
            end
        end
        expDone = modelEvent(1, 1, 0);
        applyStimulus(1, 1, 1, 0, 0, 0, 0, done, rd);
        applyStimulus(0, 0, 1, 0, 0, 1, 0, done, rd);
        checks++; if (rd !== mTotal[1]) begin errors++; $display("[TB] FAIL midrst_resume: got %0d expected %0d", rd, mTotal[1]); end
        checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_run_state: got %0b expected 0", bus.o_busy); end
    endtask

    // Scenario sequence
    initial begin
        i_rst_n          = 1'b0;
        bus.i_is_br      = 1'b0;
        bus.i_ch         = '0;
        bus.i_is_correct = 1'b1;
        bus.i_freeze     = 1'b0;
        bus.i_clear      = 1'b0;
        bus.i_rd_ch      = '0;
        bus.i_rd_sel     = 1'b0;
        modelReset();
        test_reset();
        test_basic_count();
        test_freeze_oob();
        test_epoch_alarm();
        test_random_mix();
        test_clear_sweep();
        test_saturation();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/br_pred_stats.md
Name: br_pred_stats

Overview:
Synthesizable branch-prediction statistics unit for the singlecycle RV32I core, monitored in simulation and on the DE2 board. It counts branch events and mispredictions per branch class (channel), with saturating counters. It measures the mispredict count over fixed-length epochs and raises an alarm when a threshold is exceeded. Counters are read back through an indexed port and cleared by a multi-cycle sweep.

Parameters:
CNT_W, 32, width of every total/miss counter (≥8)
NUM_CH, 4, number of branch classes (e.g. cond, jal, jalr, ret); ≥2
CH_W, $clog2(NUM_CH), channel index width (derived)
EPOCH_LOG2, 8, epoch length = 2**EPOCH_LOG2 branch events (all channels combined)
ALARM_THR, 32, epoch miss count strictly above this asserts alarm

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_is_br  in  1  branch resolved this cycle (one event max per cycle)
i_ch  in  CH_W  class of the event; sampled when i_is_br=1
i_is_correct  in  1  prediction correct; sampled when i_is_br=1
i_freeze  in  1  level; while 1, events are ignored (counters hold)
i_clear  in  1  pulse; starts clear sweep
i_rd_ch  in  CH_W  readback channel
i_rd_sel  in  1  0=total count, 1=miss count
o_rd_data  out  CNT_W  registered readback value
o_busy  out  1  clear sweep in progress
o_epoch_done  out  1  one-cycle pulse at epoch end
o_epoch_miss  out  EPOCH_LOG2+1  miss count of last completed epoch
o_alarm  out  1  sticky alarm
o_any_sat  out  1  sticky, some counter reached all-ones

Behaviour:
- Reset (async, i_rst_n=0): all counters 0, state RUN, o_rd_data=0, o_busy=0, o_epoch_done=0, o_epoch_miss=0, o_alarm=0, o_any_sat=0, epoch event/miss counters 0.
- States: RUN, CLEAR.
- RUN: accepted event = i_is_br & ~i_freeze. Out-of-range i_ch (≥NUM_CH) is dropped entirely and does not advance the epoch. On accept: total[i_ch]+=1. If ~i_is_correct, miss[i_ch]+=1. Updates are visible on the next edge.
- Saturation: a counter at 2**CNT_W-1 holds and sets o_any_sat. o_any_sat clears only via reset or a clear sweep.
- Epoch: ep_cnt counts accepted events and ep_miss counts accepted misses.
  - When an accepted event makes ep_cnt reach 2**EPOCH_LOG2, on that edge: o_epoch_miss <= ep_miss including the current event; o_epoch_done pulses 1 cycle; ep_cnt and ep_miss reset to 0.
  - If the latched value > ALARM_THR, o_alarm is set. o_alarm is sticky until a clear or reset.
- i_clear in RUN: next cycle state=CLEAR and o_busy=1. Sweep index k=0..NUM_CH-1 zeroes total[k] and miss[k], one channel per cycle. This takes exactly NUM_CH cycles with o_busy=1.
  - In the first sweep cycle, the epoch counters, o_epoch_miss, o_alarm and o_any_sat are zeroed.
  - After the last channel, state returns to RUN and o_busy=0.
  - Events arriving while o_busy=1 are dropped.
  - i_clear while in CLEAR is ignored.
  - An event in the same cycle as i_clear (in RUN) is counted, and then zeroed by the sweep.
- Readback: o_rd_data <= selected counter each cycle, a 1-cycle latency. An update and a read of the same counter in the same cycle return the pre-update value. Reads during CLEAR return the current (partly cleared) contents.
- Reset mid-sweep: returns immediately to reset state. No partial-sweep residue is observable.

Test Plan:
- Reset, then 10 events on ch2: 7 correct, 3 wrong, freeze=0 -> read ch2 sel0=10, sel1=3; other channels read 0; o_rd_data valid 1 cycle after address.
- Freeze high during 5 events; also i_ch=NUM_CH when NUM_CH is not a power of 2 -> no counter or epoch change.
- EPOCH_LOG2=4, ALARM_THR=3: 16 events with 4 misses, last event a miss -> o_epoch_done single pulse, o_epoch_miss=4, o_alarm=1. Next epoch with 0 misses -> o_epoch_miss=0, o_alarm stays 1.
- CNT_W=8: 260 correct events on ch0 -> total[0]=255, o_any_sat=1, miss[0]=0.
- Populated counters, pulse i_clear with simultaneous event, then events during busy -> o_busy high exactly NUM_CH cycles; afterwards all reads 0 and o_alarm, o_any_sat, o_epoch_miss are 0.
- Assert i_rst_n=0 mid-sweep (k=1) -> all outputs 0 asynchronously; after release, state RUN and counting resumes on the first event.
